// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator: structure encodings, legal width
// range and the maximal-length tap table.
package lfsr_pkg;

  localparam int FIBONACCI = 0;
  localparam int GALOIS    = 1;

  localparam int MIN_BITS = 3;
  localparam int MAX_BITS = 32;

  typedef struct packed {
    logic        hit;
    logic [31:0] remain;
  } seed_match_t;

  // Bit k-1 is set for every 1-based tap position k; the MSB is always a tap.
  function automatic logic [31:0] tap_mask(input int num_bits);
    logic [31:0] mask;
    case (num_bits)
      3:       mask = 32'h0000_0006;
      4:       mask = 32'h0000_000C;
      5:       mask = 32'h0000_0014;
      6:       mask = 32'h0000_0030;
      7:       mask = 32'h0000_0060;
      8:       mask = 32'h0000_00B8;
      9:       mask = 32'h0000_0110;
      10:      mask = 32'h0000_0240;
      11:      mask = 32'h0000_0500;
      12:      mask = 32'h0000_0829;
      13:      mask = 32'h0000_100D;
      14:      mask = 32'h0000_2015;
      15:      mask = 32'h0000_6000;
      16:      mask = 32'h0000_D008;
      17:      mask = 32'h0001_2000;
      18:      mask = 32'h0002_0400;
      19:      mask = 32'h0004_0023;
      20:      mask = 32'h0009_0000;
      21:      mask = 32'h0014_0000;
      22:      mask = 32'h0030_0000;
      23:      mask = 32'h0042_0000;
      24:      mask = 32'h00E1_0000;
      25:      mask = 32'h0120_0000;
      26:      mask = 32'h0200_0023;
      27:      mask = 32'h0400_0013;
      28:      mask = 32'h0900_0000;
      29:      mask = 32'h1400_0000;
      30:      mask = 32'h2000_0029;
      31:      mask = 32'h4800_0000;
      32:      mask = 32'h8020_0003;
      default: mask = 32'h0000_0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Single combinational LFSR advance for either Fibonacci or Galois structure,
// both built from the same maximal-length tap set.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS = 8,
  parameter int MODE     = FIBONACCI
) (
  input  logic [NUM_BITS-1:0] state_i,
  output logic [NUM_BITS-1:0] state_o
);

  localparam logic [NUM_BITS-1:0] TAPS = NUM_BITS'(tap_mask(NUM_BITS));
  // Galois: tap k below the MSB lands on bit k after the shift (x^N = 1 + sum x^k).
  localparam logic [NUM_BITS-1:0] GAL_MASK = TAPS << 1;

  generate
    if (MODE == GALOIS) begin : g_galois
      logic out_bit;
      assign out_bit = state_i[NUM_BITS-1];
      assign state_o = {state_i[NUM_BITS-2:0], out_bit} ^ (out_bit ? GAL_MASK : '0);
    end else begin : g_fibonacci
      assign state_o = {state_i[NUM_BITS-2:0], ^(state_i & TAPS)};
    end
  endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// Multi-step maximal-length LFSR with seed loading, all-zero lockup recovery,
// full-period detection against the last loaded seed and a step counter.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int                  NUM_BITS     = 8,
  parameter int                  MODE         = FIBONACCI,
  parameter int                  STEPS        = 1,
  parameter logic [NUM_BITS-1:0] DEFAULT_SEED = NUM_BITS'(1)
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Enable,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  output logic [NUM_BITS-1:0] o_LFSR_Data,
  output logic                o_LFSR_Done,
  output logic                o_Lockup,
  output logic [31:0]         o_Step_Cnt
);

  logic [NUM_BITS-1:0] lfsr_q, lfsr_d;
  logic [NUM_BITS-1:0] seed_q, seed_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                lockup_q, lockup_d;

  logic [STEPS-1:0]    hit;
  logic [NUM_BITS-1:0] advance_state;
  seed_match_t         match;

  generate
    if (NUM_BITS < MIN_BITS || NUM_BITS > MAX_BITS) begin : g_bad_width
      $error("lfsr_gen: NUM_BITS must be within 3..32");
    end
    if (STEPS < 1 || STEPS > NUM_BITS) begin : g_bad_steps
      $error("lfsr_gen: STEPS must be within 1..NUM_BITS");
    end
    if (DEFAULT_SEED == '0) begin : g_bad_seed
      $error("lfsr_gen: DEFAULT_SEED must be non-zero");
    end
  endgenerate

  // Cascade of single-step functions; each intermediate state is compared to the seed.
  generate
    for (genvar g = 0; g < STEPS; g++) begin : g_step
      logic [NUM_BITS-1:0] state_in;
      logic [NUM_BITS-1:0] state_out;
      if (g == 0) begin : g_first
        assign state_in = lfsr_q;
      end else begin : g_next
        assign state_in = g_step[g-1].state_out;
      end
      lfsr_step #(
        .NUM_BITS(NUM_BITS),
        .MODE    (MODE)
      ) u_step (
        .state_i(state_in),
        .state_o(state_out)
      );
      assign hit[g] = (state_out == seed_q);
    end
  endgenerate

  assign advance_state = g_step[STEPS-1].state_out;

  // A seed can match at most once per advance since the period far exceeds STEPS.
  always_comb begin
    match = '0;
    for (int k = 0; k < STEPS; k++) begin
      if (hit[k]) begin
        match.hit    = 1'b1;
        match.remain = 32'(STEPS - 1 - k);
      end
    end
  end

  always_comb begin
    lfsr_d   = lfsr_q;
    seed_d   = seed_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    lockup_d = 1'b0;
    if (i_Seed_DV) begin
      cnt_d = '0;
      if (i_Seed_Data == '0) begin
        lfsr_d   = DEFAULT_SEED;
        seed_d   = DEFAULT_SEED;
        lockup_d = 1'b1;
      end else begin
        lfsr_d = i_Seed_Data;
        seed_d = i_Seed_Data;
      end
    end else if (i_Enable) begin
      lfsr_d = advance_state;
      if (match.hit) begin
        done_d = 1'b1;
        cnt_d  = match.remain;
      end else begin
        cnt_d = cnt_q + 32'(STEPS);
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      lfsr_q   <= DEFAULT_SEED;
      seed_q   <= DEFAULT_SEED;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      seed_q   <= seed_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      lockup_q <= lockup_d;
    end
  end

  assign o_LFSR_Data = lfsr_q;
  assign o_LFSR_Done = done_q;
  assign o_Lockup    = lockup_q;
  assign o_Step_Cnt  = cnt_q;

endmodule
